// File: rtl/multicycle_control_pkg.sv
// Shared configuration for the multicycle control unit: opcodes, state and field encodings.
package multicycle_control_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned WB_SEL_W = 3;

  localparam logic [OPCODE_W-1:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_OP       = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPCODE_JAL      = 7'b1101111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_PASS_B   = 3'b000,
    ALU_ADD      = 3'b001,
    ALU_FUNC     = 3'b010,
    ALU_FUNC_ALT = 3'b011
  } alu_op_e;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_SEL_ALU = 3'b000,
    WB_SEL_MEM = 3'b001,
    WB_SEL_PC4 = 3'b010,
    WB_SEL_IMM = 3'b011
  } wb_sel_e;

  typedef struct packed {
    logic    alu_a_sel;
    logic    alu_b_sel;
    alu_op_e alu_op;
    wb_sel_e wb_sel;
    logic    is_jal;
    logic    is_jalr;
  } ctrl_fields_t;

  // Opcodes that proceed from DECODE into EXEC.
  function automatic logic is_exec_opcode(input logic [OPCODE_W-1:0] op);
    case (op)
      OPCODE_LOAD, OPCODE_STORE, OPCODE_OP, OPCODE_OP_IMM, OPCODE_AUIPC,
      OPCODE_LUI, OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_field_decoder.sv
// Per-opcode ALU operand/operation and writeback-select table.
module control_field_decoder
  import multicycle_control_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                bit_30_i,
  output ctrl_fields_t        fields_o
);

  // Pure table lookup; unsupported opcodes map to all-zero fields.
  always_comb begin
    fields_o = '0;
    case (opcode_i)
      OPCODE_LOAD: begin
        fields_o.alu_b_sel = 1'b1;
        fields_o.alu_op    = ALU_ADD;
        fields_o.wb_sel    = WB_SEL_MEM;
      end
      OPCODE_STORE: begin
        fields_o.alu_b_sel = 1'b1;
        fields_o.alu_op    = ALU_ADD;
      end
      OPCODE_JALR: begin
        fields_o.alu_b_sel = 1'b1;
        fields_o.alu_op    = ALU_ADD;
        fields_o.wb_sel    = WB_SEL_PC4;
        fields_o.is_jalr   = 1'b1;
      end
      OPCODE_OP_IMM: begin
        fields_o.alu_b_sel = 1'b1;
        fields_o.alu_op    = ALU_FUNC;
      end
      OPCODE_AUIPC: begin
        fields_o.alu_a_sel = 1'b1;
        fields_o.alu_b_sel = 1'b1;
        fields_o.alu_op    = ALU_ADD;
      end
      OPCODE_JAL: begin
        fields_o.alu_a_sel = 1'b1;
        fields_o.alu_b_sel = 1'b1;
        fields_o.alu_op    = ALU_ADD;
        fields_o.wb_sel    = WB_SEL_PC4;
        fields_o.is_jal    = 1'b1;
      end
      OPCODE_OP: begin
        fields_o.alu_op = bit_30_i ? ALU_FUNC_ALT : ALU_FUNC;
      end
      OPCODE_BRANCH: begin
        fields_o.alu_op = ALU_ADD;
      end
      OPCODE_LUI: begin
        fields_o.alu_op = ALU_PASS_B;
        fields_o.wb_sel = WB_SEL_IMM;
      end
      default: fields_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with state- and opcode-decoded outputs.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] inst_opcode,
  input  logic                inst_bit_30,
  input  logic                mem_ready,
  output logic                inst_mem_read_enable,
  output logic                ir_write_enable,
  output logic                pc_write_enable,
  output logic                regfile_write_enable,
  output logic                alu_operand_a_select,
  output logic                alu_operand_b_select,
  output logic [ALU_OP_W-1:0] alu_op_type,
  output logic                jal_enable,
  output logic                jalr_enable,
  output logic                branch_enable,
  output logic                data_mem_read_enable,
  output logic                data_mem_write_enable,
  output logic [WB_SEL_W-1:0] reg_writeback_select,
  output logic                inst_retired,
  output logic                illegal_inst
);

  state_e       state_q, state_d;
  ctrl_fields_t fields;

  control_field_decoder u_field_decoder (
    .opcode_i (inst_opcode),
    .bit_30_i (inst_bit_30),
    .fields_o (fields)
  );

  // State register; reset lands in FETCH without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  // Next state and control outputs; everything is forced low while reset is held.
  always_comb begin
    state_d               = state_q;
    inst_mem_read_enable  = 1'b0;
    ir_write_enable       = 1'b0;
    pc_write_enable       = 1'b0;
    regfile_write_enable  = 1'b0;
    alu_operand_a_select  = 1'b0;
    alu_operand_b_select  = 1'b0;
    alu_op_type           = '0;
    jal_enable            = 1'b0;
    jalr_enable           = 1'b0;
    branch_enable         = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    reg_writeback_select  = '0;
    inst_retired          = 1'b0;
    illegal_inst          = 1'b0;

    if (reset_n) begin
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        alu_operand_a_select = fields.alu_a_sel;
        alu_operand_b_select = fields.alu_b_sel;
        alu_op_type          = fields.alu_op;
      end

      case (state_q)
        ST_FETCH: begin
          inst_mem_read_enable = 1'b1;
          if (mem_ready) begin
            ir_write_enable = 1'b1;
            state_d         = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_exec_opcode(inst_opcode)) begin
            state_d = ST_EXEC;
          end else if (inst_opcode == OPCODE_MISC_MEM) begin
            pc_write_enable = 1'b1;
            inst_retired    = 1'b1;
            state_d         = ST_FETCH;
          end else begin
            pc_write_enable = 1'b1;
            illegal_inst    = 1'b1;
            state_d         = ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (inst_opcode == OPCODE_LOAD || inst_opcode == OPCODE_STORE) begin
            state_d = ST_MEM;
          end else if (inst_opcode == OPCODE_BRANCH) begin
            branch_enable   = 1'b1;
            pc_write_enable = 1'b1;
            inst_retired    = 1'b1;
            state_d         = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          if (inst_opcode == OPCODE_STORE) begin
            data_mem_write_enable = 1'b1;
            if (mem_ready) begin
              pc_write_enable = 1'b1;
              inst_retired    = 1'b1;
              state_d         = ST_FETCH;
            end
          end else begin
            data_mem_read_enable = 1'b1;
            if (mem_ready) state_d = ST_WB;
          end
        end
        ST_WB: begin
          regfile_write_enable = 1'b1;
          pc_write_enable      = 1'b1;
          inst_retired         = 1'b1;
          reg_writeback_select = fields.wb_sel;
          jal_enable           = fields.is_jal;
          jalr_enable          = fields.is_jalr;
          state_d              = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle output vectors, a monitor compares them.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [6:0] inst_opcode;
  logic       inst_bit_30;
  logic       mem_ready;
  logic       inst_mem_read_enable, ir_write_enable, pc_write_enable, regfile_write_enable;
  logic       alu_operand_a_select, alu_operand_b_select;
  logic [2:0] alu_op_type;
  logic       jal_enable, jalr_enable, branch_enable;
  logic       data_mem_read_enable, data_mem_write_enable;
  logic [2:0] reg_writeback_select;
  logic       inst_retired, illegal_inst;

  multicycle_control dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .inst_opcode           (inst_opcode),
    .inst_bit_30           (inst_bit_30),
    .mem_ready             (mem_ready),
    .inst_mem_read_enable  (inst_mem_read_enable),
    .ir_write_enable       (ir_write_enable),
    .pc_write_enable       (pc_write_enable),
    .regfile_write_enable  (regfile_write_enable),
    .alu_operand_a_select  (alu_operand_a_select),
    .alu_operand_b_select  (alu_operand_b_select),
    .alu_op_type           (alu_op_type),
    .jal_enable            (jal_enable),
    .jalr_enable           (jalr_enable),
    .branch_enable         (branch_enable),
    .data_mem_read_enable  (data_mem_read_enable),
    .data_mem_write_enable (data_mem_write_enable),
    .reg_writeback_select  (reg_writeback_select),
    .inst_retired          (inst_retired),
    .illegal_inst          (illegal_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector layout:
  // [18]imem [17]irw [16]pcw [15]rfw [14]a [13]b [12:10]op [9]jal [8]jalr [7]br [6]dmr [5]dmw [4:2]wb [1]ret [0]ill
  logic [18:0] act;
  assign act = {inst_mem_read_enable, ir_write_enable, pc_write_enable, regfile_write_enable,
                alu_operand_a_select, alu_operand_b_select, alu_op_type,
                jal_enable, jalr_enable, branch_enable, data_mem_read_enable, data_mem_write_enable,
                reg_writeback_select, inst_retired, illegal_inst};

  localparam logic [18:0] B_IMEM = 19'(1) << 18;
  localparam logic [18:0] B_IRW  = 19'(1) << 17;
  localparam logic [18:0] B_PCW  = 19'(1) << 16;
  localparam logic [18:0] B_RFW  = 19'(1) << 15;
  localparam logic [18:0] B_JAL  = 19'(1) << 9;
  localparam logic [18:0] B_JALR = 19'(1) << 8;
  localparam logic [18:0] B_BR   = 19'(1) << 7;
  localparam logic [18:0] B_DMR  = 19'(1) << 6;
  localparam logic [18:0] B_DMW  = 19'(1) << 5;
  localparam logic [18:0] B_RET  = 19'(1) << 1;
  localparam logic [18:0] B_ILL  = 19'(1);
  localparam logic [18:0] V_FGO  = B_IMEM | B_IRW;
  localparam logic [18:0] V_DONE = B_RFW | B_PCW | B_RET;

  function automatic logic [18:0] alu(input logic a, input logic b, input logic [2:0] op);
    return {4'b0000, a, b, op, 10'b0};
  endfunction

  function automatic logic [18:0] wbs(input logic [2:0] w);
    return {14'b0, w, 2'b00};
  endfunction

  typedef struct {
    logic [18:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   total = 0;
  int   bad   = 0;

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clock or chk_ev);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s t=%0t got=%b want=%b", e.tag, $time, act, e.v);
        end
      end
    end
  end

  // One clock cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic cyc(input logic rn, input logic [6:0] op, input logic b30, input logic rdy,
                     input logic [18:0] v, input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n     = rn;
    inst_opcode = op;
    inst_bit_30 = b30;
    mem_ready   = rdy;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Immediate check between clock edges.
  task automatic chk_now(input logic [18:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  // Four-cycle F/D/E/W instruction.
  task automatic run_alu(input string tag, input logic [6:0] op, input logic b30,
                         input logic rdy_mid, input logic [18:0] ev, input logic [18:0] wv);
    cyc(1'b1, op, b30, 1'b1,    V_FGO,  {tag, "_F"});
    cyc(1'b1, op, b30, rdy_mid, '0,     {tag, "_D"});
    cyc(1'b1, op, b30, rdy_mid, ev,     {tag, "_E"});
    cyc(1'b1, op, b30, rdy_mid, wv,     {tag, "_W"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    inst_opcode = OPCODE_OP;
    inst_bit_30 = 1'b0;
    mem_ready   = 1'b1;
    #2;
    chk_now('0, "rst_async");
    cyc(1'b0, OPCODE_OP, 1'b0, 1'b1, '0, "rst_hold");

    // ADD, with mem_ready low outside FETCH to show it is ignored there
    run_alu("add", OPCODE_OP, 1'b0, 1'b0, alu(0, 0, 3'b010), alu(0, 0, 3'b010) | V_DONE | wbs(3'b000));
    run_alu("sub", OPCODE_OP, 1'b1, 1'b1, alu(0, 0, 3'b011), alu(0, 0, 3'b011) | V_DONE);
    run_alu("auipc", OPCODE_AUIPC, 1'b0, 1'b1, alu(1, 1, 3'b001), alu(1, 1, 3'b001) | V_DONE);
    run_alu("lui", OPCODE_LUI, 1'b0, 1'b1, alu(0, 0, 3'b000), alu(0, 0, 3'b000) | V_DONE | wbs(3'b011));
    run_alu("jal", OPCODE_JAL, 1'b0, 1'b1, alu(1, 1, 3'b001),
            alu(1, 1, 3'b001) | V_DONE | B_JAL | wbs(3'b010));
    run_alu("jalr", OPCODE_JALR, 1'b1, 1'b1, alu(0, 1, 3'b001),
            alu(0, 1, 3'b001) | V_DONE | B_JALR | wbs(3'b010));

    // LW with a three-cycle data stall
    cyc(1'b1, OPCODE_LOAD, 1'b0, 1'b1, V_FGO, "lw_F");
    cyc(1'b1, OPCODE_LOAD, 1'b0, 1'b1, '0, "lw_D");
    cyc(1'b1, OPCODE_LOAD, 1'b0, 1'b1, alu(0, 1, 3'b001), "lw_E");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, OPCODE_LOAD, 1'b0, 1'b0, alu(0, 1, 3'b001) | B_DMR, "lw_Mstall");
    cyc(1'b1, OPCODE_LOAD, 1'b0, 1'b1, alu(0, 1, 3'b001) | B_DMR, "lw_Mdone");
    cyc(1'b1, OPCODE_LOAD, 1'b0, 1'b1, alu(0, 1, 3'b001) | V_DONE | wbs(3'b001), "lw_W");

    // SW without stall
    cyc(1'b1, OPCODE_STORE, 1'b0, 1'b1, V_FGO, "sw_F");
    cyc(1'b1, OPCODE_STORE, 1'b0, 1'b1, '0, "sw_D");
    cyc(1'b1, OPCODE_STORE, 1'b0, 1'b1, alu(0, 1, 3'b001), "sw_E");
    cyc(1'b1, OPCODE_STORE, 1'b0, 1'b1, alu(0, 1, 3'b001) | B_DMW | B_PCW | B_RET, "sw_M");

    // BEQ retires in EXEC
    cyc(1'b1, OPCODE_BRANCH, 1'b0, 1'b1, V_FGO, "beq_F");
    cyc(1'b1, OPCODE_BRANCH, 1'b0, 1'b1, '0, "beq_D");
    cyc(1'b1, OPCODE_BRANCH, 1'b0, 1'b1, alu(0, 0, 3'b001) | B_BR | B_PCW | B_RET, "beq_E");

    // Illegal opcode, then FENCE
    cyc(1'b1, 7'b1111111, 1'b0, 1'b1, V_FGO, "ill_F");
    cyc(1'b1, 7'b1111111, 1'b0, 1'b1, B_PCW | B_ILL, "ill_D");
    cyc(1'b1, OPCODE_MISC_MEM, 1'b0, 1'b1, V_FGO, "fence_F");
    cyc(1'b1, OPCODE_MISC_MEM, 1'b0, 1'b1, B_PCW | B_RET, "fence_D");

    // Fetch stalled for five cycles, then OP_IMM
    for (int i = 0; i < 5; i++)
      cyc(1'b1, OPCODE_OP_IMM, 1'b0, 1'b0, B_IMEM, "fetch_stall");
    run_alu("opimm", OPCODE_OP_IMM, 1'b0, 1'b1, alu(0, 1, 3'b010), alu(0, 1, 3'b010) | V_DONE);

    // SW interrupted by reset while stalled in MEM
    cyc(1'b1, OPCODE_STORE, 1'b0, 1'b1, V_FGO, "swr_F");
    cyc(1'b1, OPCODE_STORE, 1'b0, 1'b0, '0, "swr_D");
    cyc(1'b1, OPCODE_STORE, 1'b0, 1'b0, alu(0, 1, 3'b001), "swr_E");
    cyc(1'b1, OPCODE_STORE, 1'b0, 1'b0, alu(0, 1, 3'b001) | B_DMW, "swr_M0");
    @(posedge clock);
    #2;
    chk_now(alu(0, 1, 3'b001) | B_DMW, "swr_M1");
    #1;
    reset_n = 1'b0;
    #1;
    chk_now('0, "swr_rst_async");
    cyc(1'b0, OPCODE_STORE, 1'b0, 1'b1, '0, "swr_rst_hold");
    cyc(1'b1, OPCODE_MISC_MEM, 1'b0, 1'b1, V_FGO, "swr_refetch");
    cyc(1'b1, OPCODE_MISC_MEM, 1'b0, 1'b1, B_PCW | B_RET, "swr_fence_D");
    cyc(1'b1, OPCODE_OP, 1'b0, 1'b0, B_IMEM, "tail_F");

    repeat (2) @(posedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
